// File: rtl/controlador_entrada_autenticacao_pkg.sv
// Shared types and constants for the credential-entry controller.
// The optional inactivity timeout is enabled with AUTENTICACAO_TIMEOUT_EN.
package pkg_autenticacao;

  // Width of the comparator verdict {AUT3,AUT2,AUT1}.
  localparam int AUT_W = 3;

  // Default number of code bits, matching the 6-input comparator.
  localparam int CODE_BITS_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_PRESENT = 3'd2,
    ST_EVAL    = 3'd3,
    ST_GRANT   = 3'd4,
    ST_DENY    = 3'd5,
    ST_LOCKOUT = 3'd6
  } estado_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Largest of three interval lengths, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/controlador_entrada_autenticacao_temporizador.sv
// Loadable down-counter with a done flag. It is shared by the grant hold,
// the lockout hold and the optional inter-bit timeout, because those
// intervals never overlap in time.
module temporizador_autenticacao #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load wins over counting; counting stops at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done in the last cycle of the interval. A value of N loaded on entry
  // therefore gives exactly N cycles in the owning state.
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/controlador_entrada_autenticacao.sv
// Credential-entry controller driving the 6-bit authentication comparator.
// It collects the code serially, presents it in parallel, samples the
// comparator verdict, and grants, denies or locks out.
// Optional inter-bit timeout: define AUTENTICACAO_TIMEOUT_EN.
module controlador_entrada_autenticacao
  import pkg_autenticacao::*;
#(
  parameter int CODE_BITS      = CODE_BITS_DEF,
  parameter int MAX_TRIES      = 3,
  parameter int GRANT_CYCLES   = 4,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           BIT_IN,
  input  logic                           BIT_VALID,
  input  logic                           CANCEL,
  output logic [CODE_BITS-1:0]           CODE_OUT,
  output logic                           CODE_VALID,
  input  logic [AUT_W-1:0]               AUT_IN,
  output logic [AUT_W-1:0]               ACCESS,
  output logic                           LOCKED,
  output logic [$clog2(MAX_TRIES+1)-1:0] TRIES,
  output logic                           BUSY
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int BCNT_W  = cnt_w(CODE_BITS);
  // The timeout length takes part in sizing even when the timeout is not
  // built; this only matters if it exceeds both hold intervals.
  localparam int TMR_W   = cnt_w(max3(GRANT_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES));

  estado_t              state_q, state_d;
  logic [CODE_BITS-1:0] code_q, code_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [AUT_W-1:0]     access_q, access_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 locked_q, locked_d;

  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_en;
  logic                 tmr_done;

  logic [BCNT_W-1:0]    bcnt_inc;
  logic                 last_bit;
  logic [CODE_BITS-1:0] code_shift;

  // Failed-attempt counter saturates at MAX_TRIES instead of wrapping.
  function automatic logic [TRIES_W-1:0] sat_inc(input logic [TRIES_W-1:0] t);
    return (t >= TRIES_W'(MAX_TRIES)) ? t : t + 1'b1;
  endfunction

  // Shift left with the new bit entering the LSB, so the first bit ends as A.
  assign code_shift = (code_q << 1) | CODE_BITS'(BIT_IN);
  assign bcnt_inc   = bcnt_q + 1'b1;
  assign last_bit   = (bcnt_inc == BCNT_W'(CODE_BITS));

  temporizador_autenticacao #(
    .W (TMR_W)
  ) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // State and datapath registers; reset returns everything to idle and clears TRIES.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      bcnt_q   <= '0;
      access_q <= '0;
      tries_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bcnt_q   <= bcnt_d;
      access_q <= access_d;
      tries_q  <= tries_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic; user inputs only matter in IDLE and COLLECT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!CANCEL && BIT_VALID) begin
          state_d = (BCNT_W'(CODE_BITS) == BCNT_W'(1)) ? ST_PRESENT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (CANCEL) begin
          state_d = ST_IDLE;
        end else if (BIT_VALID) begin
          if (last_bit) state_d = ST_PRESENT;
`ifdef AUTENTICACAO_TIMEOUT_EN
        end else if (tmr_done) begin
          state_d = ST_DENY;
`endif
        end
      end
      ST_PRESENT: state_d = ST_EVAL;
      ST_EVAL:    state_d = (AUT_IN != '0) ? ST_GRANT : ST_DENY;
      ST_GRANT:   if (tmr_done) state_d = ST_IDLE;
      ST_DENY:    state_d = (tries_q == TRIES_W'(MAX_TRIES)) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (tmr_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath updates and timer control for each state.
  always_comb begin
    code_d   = code_q;
    bcnt_d   = bcnt_q;
    access_d = access_q;
    tries_d  = tries_q;
    locked_d = locked_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CANCEL) begin
          code_d = '0;
          bcnt_d = '0;
        end else if (BIT_VALID) begin
          code_d = code_shift;
          bcnt_d = BCNT_W'(1);
`ifdef AUTENTICACAO_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYCLES);
`endif
        end
      end
      ST_COLLECT: begin
        if (CANCEL) begin
          code_d = '0;
          bcnt_d = '0;
        end else if (BIT_VALID) begin
          code_d = code_shift;
          bcnt_d = bcnt_inc;
`ifdef AUTENTICACAO_TIMEOUT_EN
          // Each strobe restarts the inactivity window.
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYCLES);
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            // An abandoned entry counts as a failed attempt.
            code_d  = '0;
            bcnt_d  = '0;
            tries_d = sat_inc(tries_q);
          end
`endif
        end
      end
      ST_PRESENT: begin
        bcnt_d = '0;
      end
      ST_EVAL: begin
        if (AUT_IN != '0) begin
          access_d = AUT_IN;
          tries_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GRANT_CYCLES);
        end else begin
          tries_d = sat_inc(tries_q);
        end
      end
      ST_GRANT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          access_d = '0;
          code_d   = '0;
        end
      end
      ST_DENY: begin
        if (tries_q == TRIES_W'(MAX_TRIES)) begin
          locked_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(LOCK_CYCLES);
        end else begin
          code_d = '0;
        end
      end
      ST_LOCKOUT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          locked_d = 1'b0;
          tries_d  = '0;
        end
      end
      default: begin
        code_d = '0;
        bcnt_d = '0;
      end
    endcase
  end

  // Output decode; CODE_VALID marks the single PRESENT cycle.
  always_comb begin
    CODE_OUT   = code_q;
    CODE_VALID = (state_q == ST_PRESENT);
    ACCESS     = access_q;
    LOCKED     = locked_q;
    TRIES      = tries_q;
    BUSY       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_controlador_entrada_autenticacao.sv
// Bench for controlador_entrada_autenticacao with a transaction-level
// reference model (expected code word, attempt counter, hold lengths).
// Timeout checks follow AUTENTICACAO_TIMEOUT_EN.
module tb_controlador_entrada_autenticacao;

  localparam int CB        = 6;
  localparam int MAX_TRIES = 3;
  localparam int GRANT_N   = 4;
  localparam int LOCK_N    = 16;
  localparam int TIMEOUT_N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          BIT_IN;
  logic          BIT_VALID;
  logic          CANCEL;
  logic [CB-1:0] CODE_OUT;
  logic          CODE_VALID;
  logic [2:0]    AUT_IN;
  logic [2:0]    ACCESS;
  logic          LOCKED;
  logic [1:0]    TRIES;
  logic          BUSY;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: consecutive failures seen so far.
  logic [1:0] m_tries = 2'd0;

  controlador_entrada_autenticacao dut (
    .clk        (clk),
    .rst        (rst),
    .BIT_IN     (BIT_IN),
    .BIT_VALID  (BIT_VALID),
    .CANCEL     (CANCEL),
    .CODE_OUT   (CODE_OUT),
    .CODE_VALID (CODE_VALID),
    .AUT_IN     (AUT_IN),
    .ACCESS     (ACCESS),
    .LOCKED     (LOCKED),
    .TRIES      (TRIES),
    .BUSY       (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    BIT_IN    = b;
    BIT_VALID = 1'b1;
    tick();
    BIT_VALID = 1'b0;
  endtask

  task automatic model_fail();
    if (m_tries != 2'(MAX_TRIES)) m_tries = m_tries + 2'd1;
  endtask

  // One complete attempt: serial entry, presentation, verdict and the hold that follows.
  task automatic run_attempt(input logic [CB-1:0] code, input logic [2:0] aut);
    int exp_code;
    exp_code = 0;
    AUT_IN = aut;
    for (int i = 0; i < CB; i++) begin
      send_bit(code[CB-1-i]);
      exp_code = exp_code * 2 + int'(code[CB-1-i]);
      if (i < CB - 1) begin
        vectors++;
        if (CODE_VALID !== 1'b0 || BUSY !== 1'b1) begin
          miscompares++;
          $display("FAIL collect_bit%0d: CODE_VALID=%b BUSY=%b required 0/1", i, CODE_VALID, BUSY);
        end
      end
    end
    vectors++;
    if (CODE_VALID !== 1'b1 || CODE_OUT !== CB'(exp_code)) begin
      miscompares++;
      $display("FAIL present: CODE_VALID=%b CODE_OUT=%b required 1/%b", CODE_VALID, CODE_OUT, CB'(exp_code));
    end
    tick();
    vectors++;
    if (CODE_VALID !== 1'b0 || CODE_OUT !== CB'(exp_code)) begin
      miscompares++;
      $display("FAIL eval_hold: CODE_VALID=%b CODE_OUT=%b required 0/%b", CODE_VALID, CODE_OUT, CB'(exp_code));
    end
    tick();
    if (aut != 3'b000) begin
      m_tries = 2'd0;
      for (int k = 0; k < GRANT_N; k++) begin
        vectors++;
        if (ACCESS !== aut || TRIES !== 2'd0 || LOCKED !== 1'b0) begin
          miscompares++;
          $display("FAIL grant_c%0d: ACCESS=%b TRIES=%0d LOCKED=%b required %b/0/0", k, ACCESS, TRIES, LOCKED, aut);
        end
        tick();
      end
      vectors++;
      if (ACCESS !== 3'b000 || CODE_OUT !== '0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL grant_end: ACCESS=%b CODE_OUT=%b BUSY=%b required 000/0/0", ACCESS, CODE_OUT, BUSY);
      end
    end else begin
      model_fail();
      vectors++;
      if (TRIES !== m_tries || BUSY !== 1'b1 || ACCESS !== 3'b000) begin
        miscompares++;
        $display("FAIL deny: TRIES=%0d BUSY=%b ACCESS=%b required %0d/1/000", TRIES, BUSY, ACCESS, m_tries);
      end
      tick();
      if (m_tries == 2'(MAX_TRIES)) begin
        for (int k = 0; k < LOCK_N; k++) begin
          vectors++;
          if (LOCKED !== 1'b1 || CODE_OUT !== CB'(exp_code) || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_c%0d: LOCKED=%b CODE_OUT=%b BUSY=%b required 1/%b/1", k, LOCKED, CODE_OUT, BUSY, CB'(exp_code));
          end
          BIT_VALID = 1'($urandom);
          BIT_IN    = 1'($urandom);
          CANCEL    = 1'($urandom);
          tick();
        end
        BIT_VALID = 1'b0;
        CANCEL    = 1'b0;
        m_tries   = 2'd0;
        vectors++;
        if (LOCKED !== 1'b0 || TRIES !== 2'd0 || BUSY !== 1'b0) begin
          miscompares++;
          $display("FAIL lock_end: LOCKED=%b TRIES=%0d BUSY=%b required 0/0/0", LOCKED, TRIES, BUSY);
        end
      end else begin
        vectors++;
        if (BUSY !== 1'b0 || CODE_OUT !== '0 || LOCKED !== 1'b0) begin
          miscompares++;
          $display("FAIL deny_end: BUSY=%b CODE_OUT=%b LOCKED=%b required 0/0/0", BUSY, CODE_OUT, LOCKED);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (CODE_OUT !== '0 || CODE_VALID !== 1'b0 || ACCESS !== 3'b000 ||
        LOCKED !== 1'b0 || TRIES !== 2'd0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: CODE_OUT=%b CODE_VALID=%b ACCESS=%b LOCKED=%b TRIES=%0d BUSY=%b required all zero",
               tag, CODE_OUT, CODE_VALID, ACCESS, LOCKED, TRIES, BUSY);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tries = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; BIT_IN = 1'b0; BIT_VALID = 1'b0; CANCEL = 1'b0; AUT_IN = 3'b000;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    m_tries = 2'd0;
  endtask

  task automatic test_grant_basic();
    run_attempt(6'b011000, 3'b001);
  endtask

  task automatic test_lockout();
    for (int n = 0; n < MAX_TRIES; n++) run_attempt(CB'($urandom), 3'b000);
  endtask

  task automatic test_cancel();
    run_attempt(CB'($urandom), 3'b000);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    CANCEL = 1'b1; BIT_VALID = 1'b1; BIT_IN = 1'($urandom);
    tick();
    CANCEL = 1'b0; BIT_VALID = 1'b0;
    vectors++;
    if (BUSY !== 1'b0 || CODE_OUT !== '0 || TRIES !== m_tries) begin
      miscompares++;
      $display("FAIL cancel: BUSY=%b CODE_OUT=%b TRIES=%0d required 0/0/%0d", BUSY, CODE_OUT, TRIES, m_tries);
    end
    run_attempt(CB'($urandom), 3'($urandom_range(1, 7)));
  endtask

  task automatic test_fail_then_success();
    apply_reset();
    run_attempt(CB'($urandom), 3'b000);
    run_attempt(CB'($urandom), 3'b000);
    vectors++;
    if (TRIES !== 2'd2) begin
      miscompares++;
      $display("FAIL two_fails: TRIES=%0d required 2", TRIES);
    end
    run_attempt(CB'($urandom), 3'b100);
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tries = 2'd0;
    check_reset_outputs("reset_collect");
    AUT_IN = 3'b010;
    for (int i = 0; i < CB; i++) send_bit(1'($urandom));
    tick();
    tick();
    tick();
    vectors++;
    if (ACCESS !== 3'b010) begin
      miscompares++;
      $display("FAIL pre_reset_grant: ACCESS=%b required 010", ACCESS);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_grant");
    run_attempt(CB'($urandom), 3'b011);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_attempt(CB'($urandom), a);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_bit(1'($urandom));
    send_bit(1'($urandom));
    for (int k = 0; k < TIMEOUT_N; k++) tick();
`ifdef AUTENTICACAO_TIMEOUT_EN
    model_fail();
    vectors++;
    if (TRIES !== m_tries || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_deny: TRIES=%0d BUSY=%b required %0d/1", TRIES, BUSY, m_tries);
    end
    tick();
    vectors++;
    if (BUSY !== 1'b0 || CODE_OUT !== '0) begin
      miscompares++;
      $display("FAIL timeout_idle: BUSY=%b CODE_OUT=%b required 0/0", BUSY, CODE_OUT);
    end
`else
    tick();
    vectors++;
    if (BUSY !== 1'b1 || TRIES !== m_tries || CODE_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout: BUSY=%b TRIES=%0d CODE_VALID=%b required 1/%0d/0", BUSY, TRIES, CODE_VALID, m_tries);
    end
    CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    vectors++;
    if (BUSY !== 1'b0 || CODE_OUT !== '0) begin
      miscompares++;
      $display("FAIL no_timeout_cancel: BUSY=%b CODE_OUT=%b required 0/0", BUSY, CODE_OUT);
    end
`endif
    run_attempt(CB'($urandom), 3'b001);
  endtask

  initial begin
    test_reset();
    test_grant_basic();
    test_lockout();
    test_cancel();
    test_fail_then_success();
    test_reset_midway();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controlador_entrada_autenticacao.md
Name: controlador_entrada_autenticacao

Overview:
- Sequential credential-entry controller that drives the 6-bit authentication comparator.
- It collects a user code serially, one bit per valid strobe, and presents it as parallel lines A..F.
- It samples the comparator's AUT1..AUT3 verdict and then grants access, denies access, or enforces a lockout after repeated failures.
- It is the initiator side of the comparator interface: it sits between the user input logic and the comparator.

Parameters:
- CODE_BITS, 6, number of code bits collected; must match comparator input count.
- MAX_TRIES, 3, consecutive denied attempts that trigger lockout.
- GRANT_CYCLES, 4, cycles ACCESS is held after a successful check.
- LOCK_CYCLES, 16, cycles LOCKED is held during lockout.
- TIMEOUT_CYCLES, 8, inter-bit idle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- BIT_IN  in  1  code bit; sampled when BIT_VALID=1.
- BIT_VALID  in  1  one-cycle strobe qualifying BIT_IN.
- CANCEL  in  1  abort the entry in progress.
- CODE_OUT  out  CODE_BITS  parallel code to the comparator; bit[CODE_BITS-1]=A … bit[0]=F.
- CODE_VALID  out  1  one-cycle pulse; CODE_OUT is stable while it is high.
- AUT_IN  in  3  comparator verdict {AUT3,AUT2,AUT1}.
- ACCESS  out  3  latched verdict, driven during GRANT.
- LOCKED  out  1  high during lockout.
- TRIES  out  $clog2(MAX_TRIES+1)  consecutive failed attempts.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. rst has priority over everything.
- Reset values: CODE_OUT=0, CODE_VALID=0, ACCESS=0, LOCKED=0, TRIES=0, BUSY=0, state=IDLE, bit counter=0.
- Reset mid-operation aborts any state on the next edge. A partial code is discarded and TRIES is cleared.
- States: IDLE, COLLECT, PRESENT, EVAL, GRANT, DENY, LOCKOUT.
- IDLE:
  - BIT_VALID=1 shifts BIT_IN into the code register (shift left, new bit into LSB).
  - The bit counter becomes 1 and the state goes to COLLECT.
  - The first bit received ends up as A.
- COLLECT:
  - Each BIT_VALID shifts one bit and increments the counter.
  - On the edge that stores bit number CODE_BITS, go to PRESENT.
- CANCEL in IDLE or COLLECT:
  - Clears the shift register and counter, then returns to IDLE.
  - TRIES is unchanged.
  - CANCEL and BIT_VALID in the same cycle: CANCEL wins and the bit is dropped.
- PRESENT:
  - CODE_OUT already holds the full code.
  - CODE_VALID=1 for exactly this one cycle, then go to EVAL.
  - Latency: CODE_VALID is asserted in the cycle after the last BIT_VALID.
- EVAL:
  - AUT_IN is registered on this edge; CODE_OUT is held.
  - The comparator is combinational, so AUT_IN is valid in the cycle after CODE_VALID.
  - AUT_IN != 0: ACCESS <= AUT_IN, TRIES <= 0, go to GRANT.
  - AUT_IN == 0: TRIES <= TRIES+1, go to DENY.
- GRANT: ACCESS is held for GRANT_CYCLES cycles, then ACCESS <= 0, CODE_OUT <= 0, go to IDLE.
- DENY: one cycle. If TRIES == MAX_TRIES, go to LOCKOUT; else CODE_OUT <= 0 and go to IDLE.
- LOCKOUT:
  - LOCKED=1 for LOCK_CYCLES cycles, then LOCKED <= 0, TRIES <= 0, go to IDLE.
- Inputs ignored outside IDLE/COLLECT: BIT_VALID and CANCEL are ignored in PRESENT, EVAL, GRANT, DENY and LOCKOUT.
- TRIES saturates at MAX_TRIES and never wraps.
- The cycle counter is loaded on state entry and counts down to 1. Holding time is exactly the parameter value.

Optional Feature:
- Macro: AUTENTICACAO_TIMEOUT_EN.
- Defined: in COLLECT, an idle counter is reset on each BIT_VALID. After TIMEOUT_CYCLES consecutive cycles without BIT_VALID, the partial code is discarded and the attempt counts as a failure via DENY (TRIES increments, lockout rules apply). CANCEL still takes priority over the timeout.
- Undefined: COLLECT waits indefinitely. TIMEOUT_CYCLES is unused and no idle counter is built.

Decomposition:
- Package pkg_autenticacao holds:
  - the state enum;
  - AUT_W=3;
  - default CODE_BITS;
  - a localparam function for counter widths.
- One sub-module, temporizador_autenticacao: a loadable down-counter with a done flag. It is shared for the GRANT, LOCKOUT and timeout intervals, since these are mutually exclusive.

Test Plan:
- Reset, then bits 0,1,1,0,0,0 with the bench responder returning AUT_IN=3'b001 -> CODE_OUT=6'b011000; CODE_VALID high for one cycle, in the cycle after the 6th strobe; ACCESS=3'b001 for 4 cycles, then 0; TRIES=0.
- Three codes in a row with AUT_IN=0 -> TRIES goes 1,2,3; after the third DENY, LOCKED=1 for 16 cycles. BIT_VALID during lockout is ignored (CODE_OUT unchanged). After lockout, TRIES=0 and BUSY=0.
- Enter 3 bits, then CANCEL together with BIT_VALID -> IDLE, bit dropped, TRIES unchanged. A following full 6-bit entry presents only the new bits.
- Two failures, then a success with AUT_IN=3'b100 -> TRIES resets 2 -> 0, ACCESS=3'b100, no lockout.
- Assert rst during COLLECT (4 bits in) and again during GRANT -> all outputs return to their reset values on the next edge; a following entry behaves normally.
- With AUTENTICACAO_TIMEOUT_EN defined: 2 bits, then 8 idle cycles -> DENY and TRIES=1. Undefined: the same stimulus stays in COLLECT with BUSY=1.
